// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Opcodes, functs, states, select codes and instruction classes.
package mc_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // FSM state encoding; 5..7 are unreachable
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // ALU operations
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;

    // Next-PC select
    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    // GRF write-address select
    localparam logic [1:0] RA_RD = 2'd0;
    localparam logic [1:0] RA_RT = 2'd1;
    localparam logic [1:0] RA_31 = 2'd2;

    // GRF write-data select
    localparam logic [2:0] RD_ALU = 3'd0;
    localparam logic [2:0] RD_DM  = 3'd1;
    localparam logic [2:0] RD_LUI = 3'd2;
    localparam logic [2:0] RD_PC4 = 3'd3;
    localparam logic [2:0] RD_LH  = 3'd4;
    localparam logic [2:0] RD_SLT = 3'd5;

    // ALU B-operand select
    localparam logic [2:0] ALUB_RD2 = 3'd0;
    localparam logic [2:0] ALUB_SXT = 3'd1;
    localparam logic [2:0] ALUB_ZXT = 3'd2;
    localparam logic [2:0] ALUB_SHA = 3'd3;

    // Instruction classes
    typedef enum logic [3:0] {
        R_ALU   = 4'd0,
        SHIFT   = 4'd1,
        IMM_OR  = 4'd2,
        LUI     = 4'd3,
        LOAD_W  = 4'd4,
        LOAD_H  = 4'd5,
        STORE   = 4'd6,
        BEQ     = 4'd7,
        J       = 4'd8,
        JAL     = 4'd9,
        JR      = 4'd10,
        ILLEGAL = 4'd11
    } iclass_e;

    // State in which an instruction of class c completes
    function automatic state_e fin_state(iclass_e c);
        state_e s;
        s = S_EXEC;
        case (c)
            R_ALU, SHIFT, IMM_OR, LUI: s = S_WB;
            LOAD_W, LOAD_H:            s = S_WB;
            STORE:                     s = S_MEM;
            default:                   s = S_EXEC;
        endcase
        return s;
    endfunction

    // Class needs a data-memory cycle after EXEC
    function automatic logic needs_mem(iclass_e c);
        return (c == LOAD_W) || (c == LOAD_H) || (c == STORE);
    endfunction

    // Class writes the register file in its final cycle
    function automatic logic writes_reg(iclass_e c);
        logic w;
        w = 1'b0;
        case (c)
            R_ALU, SHIFT, IMM_OR, LUI: w = 1'b1;
            LOAD_W, LOAD_H, JAL:       w = 1'b1;
            default:                   w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle controller.
// Maps opcode/funct of the latched IR to a class and static selects.
import mc_ctrl_pkg::*;

module mc_decode (
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output iclass_e    o_cls,
    output logic       o_a1_op,
    output logic [1:0] o_reg_addr_op,
    output logic [2:0] o_reg_data_op,
    output logic [3:0] o_alu_op,
    output logic [2:0] o_alu_b_op,
    output logic [2:0] o_next_pc_op
);

    iclass_e w_cls;

    // Classify the instruction from opcode and, for R-type, funct
    always_comb begin
        w_cls = ILLEGAL;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: w_cls = R_ALU;
                    FN_SUBU: w_cls = R_ALU;
                    FN_SLT:  w_cls = R_ALU;
                    FN_SLL:  w_cls = SHIFT;
                    FN_JR:   w_cls = JR;
                    default: w_cls = ILLEGAL;
                endcase
            end
            OP_ORI:  w_cls = IMM_OR;
            OP_LUI:  w_cls = LUI;
            OP_LW:   w_cls = LOAD_W;
            OP_LH:   w_cls = LOAD_H;
            OP_SW:   w_cls = STORE;
            OP_BEQ:  w_cls = BEQ;
            OP_J:    w_cls = J;
            OP_JAL:  w_cls = JAL;
            default: w_cls = ILLEGAL;
        endcase
    end

    // Static datapath selects for the decoded class
    always_comb begin
        o_a1_op       = 1'b0;
        o_reg_addr_op = RA_RD;
        o_reg_data_op = RD_ALU;
        o_alu_op      = ALU_ADD;
        o_alu_b_op    = ALUB_RD2;
        o_next_pc_op  = NPC_PC4;
        case (w_cls)
            R_ALU: begin
                o_reg_addr_op = RA_RD;
                o_alu_b_op    = ALUB_RD2;
                if (i_funct == FN_ADDU) begin
                    o_alu_op      = ALU_ADD;
                    o_reg_data_op = RD_ALU;
                end else if (i_funct == FN_SUBU) begin
                    o_alu_op      = ALU_SUB;
                    o_reg_data_op = RD_ALU;
                end else begin
                    o_alu_op      = ALU_SUB;
                    o_reg_data_op = RD_SLT;
                end
            end
            SHIFT: begin
                o_a1_op       = 1'b1;
                o_alu_b_op    = ALUB_SHA;
                o_alu_op      = ALU_SLL;
                o_reg_addr_op = RA_RD;
                o_reg_data_op = RD_ALU;
            end
            IMM_OR: begin
                o_alu_b_op    = ALUB_ZXT;
                o_alu_op      = ALU_OR;
                o_reg_addr_op = RA_RT;
                o_reg_data_op = RD_ALU;
            end
            LUI: begin
                o_reg_addr_op = RA_RT;
                o_reg_data_op = RD_LUI;
            end
            LOAD_W, LOAD_H: begin
                o_alu_b_op    = ALUB_SXT;
                o_alu_op      = ALU_ADD;
                o_reg_addr_op = RA_RT;
                o_reg_data_op = (w_cls == LOAD_W) ? RD_DM : RD_LH;
            end
            STORE: begin
                o_alu_b_op = ALUB_SXT;
                o_alu_op   = ALU_ADD;
            end
            BEQ: begin
                o_alu_b_op   = ALUB_RD2;
                o_alu_op     = ALU_SUB;
                o_next_pc_op = NPC_BEQ;
            end
            J: begin
                o_next_pc_op = NPC_J;
            end
            JAL: begin
                o_next_pc_op  = NPC_J;
                o_reg_addr_op = RA_31;
                o_reg_data_op = RD_PC4;
            end
            JR: begin
                o_next_pc_op = NPC_JR;
            end
            default: begin
                o_next_pc_op = NPC_PC4;
            end
        endcase
    end

    assign o_cls = w_cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: IR latch, state sequencing,
// write-strobe gating and retired-instruction counter.
import mc_ctrl_pkg::*;

module mc_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    output logic [31:0]          ir,
    output logic                 pc_write,
    output logic [2:0]           next_pc_op,
    output logic                 reg_write,
    output logic                 a1_op,
    output logic [1:0]           reg_addr_op,
    output logic [2:0]           reg_data_op,
    output logic [3:0]           alu_op,
    output logic [2:0]           alu_b_op,
    output logic                 mem_write,
    output logic [2:0]           state,
    output logic                 retire,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    state_e                r_state;
    logic [31:0]           r_ir;
    logic [CNT_WIDTH-1:0]  r_cnt;

    iclass_e               w_cls;
    logic                  w_final;
    logic                  w_fire;

    mc_decode u_decode (
        .i_op          (r_ir[31:26]),
        .i_funct       (r_ir[5:0]),
        .o_cls         (w_cls),
        .o_a1_op       (a1_op),
        .o_reg_addr_op (reg_addr_op),
        .o_reg_data_op (reg_data_op),
        .o_alu_op      (alu_op),
        .o_alu_b_op    (alu_b_op),
        .o_next_pc_op  (next_pc_op)
    );

    // Last cycle of the instruction; never true in states 5..7
    assign w_final = (r_state == fin_state(w_cls));

    // Strobes fire only in the final cycle and never under reset
    assign w_fire    = w_final && !reset;
    assign pc_write  = w_fire;
    assign retire    = w_fire;
    assign reg_write = w_fire && writes_reg(w_cls);
    assign mem_write = w_fire && (w_cls == STORE);
    assign illegal   = w_fire && (w_cls == ILLEGAL);

    // FSM and IR latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= instr;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_final)
                        r_state <= S_FETCH;
                    else if (needs_mem(w_cls))
                        r_state <= S_MEM;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    r_state <= w_final ? S_FETCH : S_WB;
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (retire)
            r_cnt <= r_cnt + 1'b1;
    end

    assign ir          = r_ir;
    assign state       = r_state;
    assign retired_cnt = r_cnt;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS datapath, which is being converted from single-cycle to multi-cycle.
- Latches the instruction from IM into an internal IR and decodes it.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath mux selects and one-cycle write strobes (pc_write, reg_write, mem_write).
- Counts retired instructions and flags illegal encodings.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
instr  in  32  IM output for current PC.
ir  out  32  latched instruction; datapath takes rs/rt/rd/shamt/imm/j_address from this.
pc_write  out  1  PC loads the next_pc_op-selected value at this edge.
next_pc_op  out  3  0=pc+4, 1=beq target (datapath tests alu_out==0), 2=j/jal, 3=jr.
reg_write  out  1  GRF write strobe.
a1_op  out  1  1 = GRF port-1 address is rt (sll).
reg_addr_op  out  2  0=rd, 1=rt, 2=$31.
reg_data_op  out  3  0=alu, 1=dm, 2=lui, 3=pc+4, 4=lh, 5=slt.
alu_op  out  4  0=ADD, 1=SUB, 2=OR, 3=SLL.
alu_b_op  out  3  0=read2, 1=sign-ext imm, 2=zero-ext imm, 3=shamt.
mem_write  out  1  DM write strobe.
state  out  3  current FSM state, for debug/testbench.
retire  out  1  one-cycle pulse in the final cycle of each instruction.
illegal  out  1  one-cycle pulse in EXEC of an undecodable instruction.
retired_cnt  out  CNT_WIDTH  number of retired instructions; wraps modulo 2^CNT_WIDTH.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Values 5–7 are unreachable; if entered, go to FETCH next cycle with all strobes 0.
- Reset (synchronous):
  - state=FETCH, ir=0, retired_cnt=0.
  - pc_write, reg_write, mem_write, retire and illegal are forced 0 while reset=1, regardless of state.
  - Reset mid-instruction abandons it; no write happens in the reset cycle.
- FETCH: ir<=instr at the edge; next state DECODE.
- DECODE: no strobes; next state EXEC.
- Selects: all mux selects are combinational from ir. They are held constant from DECODE through the final cycle of the instruction.
- PC stability: PC changes only in the final cycle, via pc_write, so pc+4 and the beq target reference the instruction's own PC.
- Per-class sequence (final cycle asserts pc_write, retire and any write strobe):
  - addu/subu/slt (R, funct 21/23/2A): EXEC -> WB. reg_write in WB; reg_addr_op=0; alu_b_op=0; alu_op ADD/SUB/SUB; reg_data_op 0/0/5. Total 4 cycles.
  - sll (funct 00, includes nop 0x00000000): EXEC -> WB. a1_op=1, alu_b_op=3, alu_op=SLL, reg_addr_op=0, reg_data_op=0. Total 4 cycles.
  - ori (0D): alu_b_op=2, alu_op=OR, reg_addr_op=1, reg_data_op=0, write in WB. Total 4 cycles.
  - lui (0F): reg_addr_op=1, reg_data_op=2, write in WB. Total 4 cycles.
  - lw (23) / lh (21): EXEC -> MEM -> WB. alu_b_op=1, alu_op=ADD, reg_addr_op=1, reg_data_op=1 (lw) or 4 (lh). Total 5 cycles.
  - sw (2B): EXEC -> MEM. alu_b_op=1, alu_op=ADD; mem_write and pc_write in MEM. Total 4 cycles.
  - beq (04): final cycle EXEC. alu_b_op=0, alu_op=SUB, next_pc_op=1. Total 3 cycles.
  - j (02): final cycle EXEC, next_pc_op=2. Total 3 cycles.
  - jal (03): final cycle EXEC, next_pc_op=2, reg_write, reg_addr_op=2, reg_data_op=3 (same edge as the PC update). Total 3 cycles.
  - jr (funct 08): final cycle EXEC, next_pc_op=3. Total 3 cycles.
  - Any other encoding: final cycle EXEC. illegal=1, pc_write with next_pc_op=0, no reg/mem write. It counts as retired.
- Non-final cycles: pc_write=reg_write=mem_write=0. next_pc_op defaults to 0 when not a jump/branch.
- After the final cycle, next state is FETCH.
- retired_cnt increments at every edge where retire=1.

Decomposition:
- Package mc_ctrl_pkg:
  - opcode and funct constants;
  - state encoding;
  - ALU_* op codes;
  - NPC_*, RA_*, RD_*, ALUB_* select encodings;
  - instruction-class enum (R_ALU, SHIFT, IMM_OR, LUI, LOAD_W, LOAD_H, STORE, BEQ, J, JAL, JR, ILLEGAL).
- Sub-module mc_decode: purely combinational. Maps ir to instruction class plus static selects (a1_op, reg_addr_op, reg_data_op, alu_op, alu_b_op, next_pc_op).
- mc_ctrl holds the IR, the FSM, strobe gating and the counter.

Test Plan:
1. reset=1 for 2 cycles with instr=0x3C011234 -> state=0, ir=0, all strobes 0, retired_cnt=0. Release reset -> ir=0x3C011234 after FETCH; WB at cycle 4 with reg_write=1, reg_addr_op=1, reg_data_op=2, pc_write=1.
2. lw 0x8C220004 -> exactly 5 cycles; reg_write only in WB with reg_data_op=1; mem_write never asserted. sw 0xAC220004 -> 4 cycles; mem_write=1 and pc_write=1 only in MEM.
3. beq 0x10220003 -> pc_write=1, next_pc_op=1, alu_op=1 in cycle 3; state returns to FETCH. jal 0x0C000C00 -> cycle 3 has reg_write=1, reg_addr_op=2, reg_data_op=3, next_pc_op=2.
4. sll 0x00021080 -> a1_op=1, alu_b_op=3, alu_op=3 held from DECODE through WB. Illegal 0xFC000000 -> illegal=1 and retire=1 in EXEC; no reg/mem write.
5. Assert reset in MEM of a sw -> mem_write=0 that cycle; state=FETCH next cycle; retired_cnt=0.
6. CNT_WIDTH=4: retire 17 j instructions -> retired_cnt=1 (wrap). Each j takes exactly 3 cycles.
